// File: rtl/parser_pkg.sv
// ============================================================================
// parser_pkg : message type encoding shared by the UART RX parser and dispatcher
// Revision   : 1.0
// ============================================================================
`default_nettype none

package parser_pkg;

  typedef enum logic [2:0] {
    MSG_NONE       = 3'd0,
    MSG_REG_WRITE  = 3'd1,
    MSG_PIXEL      = 3'd2,
    MSG_BURST_HDR  = 3'd3,
    MSG_BURST_DATA = 3'd4,
    MSG_STATUS     = 3'd5
  } msg_type_e;

endpackage

`default_nettype wire

// File: rtl/uart_msg_dispatcher_if.sv
// ============================================================================
// uart_msg_dispatcher_if : RX message, RGF write and pixel stream bundle
// Revision               : 1.0
// ============================================================================
`default_nettype none

interface uart_msg_dispatcher_if;
  import parser_pkg::*;

  logic        sys_data_available;
  logic        sys_valid_msg;
  msg_type_e   sys_classified_type;
  logic [7:0]  sys_parsed_addr;
  logic [15:0] sys_parsed_offset_addr;
  logic [15:0] sys_parsed_data_high;
  logic [15:0] sys_parsed_data_low;
  logic [31:0] sys_parsed_height;
  logic [31:0] sys_parsed_width;
  logic [7:0]  sys_pixel_r;
  logic [7:0]  sys_pixel_g;
  logic [7:0]  sys_pixel_b;
  logic [31:0] sys_burst_red;
  logic [31:0] sys_burst_green;
  logic [31:0] sys_burst_blue;
  logic        sys_seq_ready;
  logic        sys_burst_done;
  logic        rgf_wr_en;
  logic [7:0]  rgf_addr;
  logic [15:0] rgf_offset;
  logic [31:0] rgf_wdata;
  logic        rgf_ready;
  logic        pix_valid;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic        pix_last;
  logic        pix_ready;
  logic        burst_active;
  logic        err_pulse;

  // Master: RX side and sinks (drives messages and ready inputs)
  modport master (
    output sys_data_available, sys_valid_msg, sys_classified_type,
           sys_parsed_addr, sys_parsed_offset_addr, sys_parsed_data_high,
           sys_parsed_data_low, sys_parsed_height, sys_parsed_width,
           sys_pixel_r, sys_pixel_g, sys_pixel_b,
           sys_burst_red, sys_burst_green, sys_burst_blue,
           rgf_ready, pix_ready,
    input  sys_seq_ready, sys_burst_done, rgf_wr_en, rgf_addr, rgf_offset,
           rgf_wdata, pix_valid, pix_r, pix_g, pix_b, pix_last,
           burst_active, err_pulse
  );

  modport slave (
    input  sys_data_available, sys_valid_msg, sys_classified_type,
           sys_parsed_addr, sys_parsed_offset_addr, sys_parsed_data_high,
           sys_parsed_data_low, sys_parsed_height, sys_parsed_width,
           sys_pixel_r, sys_pixel_g, sys_pixel_b,
           sys_burst_red, sys_burst_green, sys_burst_blue,
           rgf_ready, pix_ready,
    output sys_seq_ready, sys_burst_done, rgf_wr_en, rgf_addr, rgf_offset,
           rgf_wdata, pix_valid, pix_r, pix_g, pix_b, pix_last,
           burst_active, err_pulse
  );

endinterface

`default_nettype wire

// File: rtl/uart_msg_dispatcher.sv
// ============================================================================
// uart_msg_dispatcher : sequences synchronized RX messages to RGF/pixel sinks
// Revision            : 1.0
// ============================================================================
`default_nettype none

module uart_msg_dispatcher
  import parser_pkg::*;
#(
  parameter logic [31:0] MAX_PIXELS = 32'd921600,
  parameter int          DONE_HOLD  = 4
) (
  input  logic                    clk_sys,
  input  logic                    rst_sys,
  uart_msg_dispatcher_if.slave    bus
);

  localparam int             CW        = $clog2(DONE_HOLD + 1);
  localparam logic [CW-1:0]  DONE_LOAD = CW'(DONE_HOLD);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RGF_WR       = 3'd1,
    ST_PIX_WR       = 3'd2,
    ST_BURST_UNPACK = 3'd3,
    ST_ACK          = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic           seq_ready_q, seq_ready_d;
  logic           burst_done_q, burst_done_d;
  logic           rgf_wr_en_q, rgf_wr_en_d;
  logic [7:0]     rgf_addr_q, rgf_addr_d;
  logic [15:0]    rgf_offset_q, rgf_offset_d;
  logic [31:0]    rgf_wdata_q, rgf_wdata_d;
  logic           pix_valid_q, pix_valid_d;
  logic [7:0]     pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic           pix_last_q, pix_last_d;
  logic           burst_active_q, burst_active_d;
  logic           err_q, err_d;
  logic [31:0]    remaining_q, remaining_d;
  logic [1:0]     lane_q, lane_d;
  logic [CW-1:0]  done_cnt_q, done_cnt_d;
  logic [31:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [63:0]    size64;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] k);
    logic [31:0] s;
    s = w >> {k, 3'b000};
    return s[7:0];
  endfunction

  always_comb begin
    state_d        = state_q;
    seq_ready_d    = seq_ready_q;
    burst_done_d   = burst_done_q;
    rgf_wr_en_d    = rgf_wr_en_q;
    rgf_addr_d     = rgf_addr_q;
    rgf_offset_d   = rgf_offset_q;
    rgf_wdata_d    = rgf_wdata_q;
    pix_valid_d    = pix_valid_q;
    pix_r_d        = pix_r_q;
    pix_g_d        = pix_g_q;
    pix_b_d        = pix_b_q;
    pix_last_d     = pix_last_q;
    burst_active_d = burst_active_q;
    err_d          = 1'b0;
    remaining_d    = remaining_q;
    lane_d         = lane_q;
    done_cnt_d     = done_cnt_q;
    red_d          = red_q;
    green_d        = green_q;
    blue_d         = blue_q;
    size64         = {32'd0, bus.sys_parsed_height} * {32'd0, bus.sys_parsed_width};

    // The done hold runs independently of message sequencing
    if (done_cnt_q != '0) begin
      done_cnt_d   = done_cnt_q - 1'b1;
      burst_done_d = (done_cnt_q != 1);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.sys_data_available) begin
          red_d        = bus.sys_burst_red;
          green_d      = bus.sys_burst_green;
          blue_d       = bus.sys_burst_blue;
          rgf_addr_d   = bus.sys_parsed_addr;
          rgf_offset_d = bus.sys_parsed_offset_addr;
          rgf_wdata_d  = {bus.sys_parsed_data_high, bus.sys_parsed_data_low};
          pix_r_d      = bus.sys_pixel_r;
          pix_g_d      = bus.sys_pixel_g;
          pix_b_d      = bus.sys_pixel_b;
          state_d      = ST_ACK;
          seq_ready_d  = 1'b1;
          if (!bus.sys_valid_msg) begin
            err_d = 1'b1;
          end else begin
            case (bus.sys_classified_type)
              MSG_REG_WRITE: begin
                state_d     = ST_RGF_WR;
                seq_ready_d = 1'b0;
                rgf_wr_en_d = 1'b1;
              end
              MSG_PIXEL: begin
                state_d     = ST_PIX_WR;
                seq_ready_d = 1'b0;
                pix_valid_d = 1'b1;
                pix_last_d  = 1'b0;
              end
              MSG_BURST_HDR: begin
                if ((size64[63:32] != 32'd0) || (size64[31:0] == 32'd0) ||
                    (size64[31:0] > MAX_PIXELS)) begin
                  err_d = 1'b1;
                end else begin
                  err_d          = burst_active_q;
                  remaining_d    = size64[31:0];
                  burst_active_d = 1'b1;
                end
              end
              MSG_BURST_DATA: begin
                if (burst_active_q) begin
                  state_d     = ST_BURST_UNPACK;
                  seq_ready_d = 1'b0;
                  lane_d      = 2'd0;
                  pix_valid_d = 1'b1;
                  pix_r_d     = bus.sys_burst_red[7:0];
                  pix_g_d     = bus.sys_burst_green[7:0];
                  pix_b_d     = bus.sys_burst_blue[7:0];
                  pix_last_d  = (remaining_q == 32'd1);
                end else begin
                  err_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end

      ST_RGF_WR: begin
        if (bus.rgf_ready) begin
          rgf_wr_en_d = 1'b0;
          seq_ready_d = 1'b1;
          state_d     = ST_ACK;
        end
      end

      ST_PIX_WR: begin
        if (bus.pix_ready) begin
          pix_valid_d = 1'b0;
          seq_ready_d = 1'b1;
          state_d     = ST_ACK;
        end
      end

      ST_BURST_UNPACK: begin
        if (bus.pix_ready) begin
          remaining_d = (remaining_q != 32'd0) ? remaining_q - 32'd1 : 32'd0;
          lane_d      = lane_q + 2'd1;
          if (remaining_q == 32'd1) begin
            burst_active_d = 1'b0;
            done_cnt_d     = DONE_LOAD;
            burst_done_d   = 1'b1;
          end
          // Spare lanes of a short final word are simply never emitted
          if ((lane_q == 2'd3) || (remaining_q <= 32'd1)) begin
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            seq_ready_d = 1'b1;
            state_d     = ST_ACK;
          end else begin
            pix_r_d    = lane_byte(red_q, lane_q + 2'd1);
            pix_g_d    = lane_byte(green_q, lane_q + 2'd1);
            pix_b_d    = lane_byte(blue_q, lane_q + 2'd1);
            pix_last_d = (remaining_q == 32'd2);
          end
        end
      end

      ST_ACK: begin
        if (!bus.sys_data_available) begin
          seq_ready_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q        <= ST_IDLE;
      seq_ready_q    <= 1'b0;
      burst_done_q   <= 1'b0;
      rgf_wr_en_q    <= 1'b0;
      rgf_addr_q     <= '0;
      rgf_offset_q   <= '0;
      rgf_wdata_q    <= '0;
      pix_valid_q    <= 1'b0;
      pix_r_q        <= '0;
      pix_g_q        <= '0;
      pix_b_q        <= '0;
      pix_last_q     <= 1'b0;
      burst_active_q <= 1'b0;
      err_q          <= 1'b0;
      remaining_q    <= '0;
      lane_q         <= '0;
      done_cnt_q     <= '0;
      red_q          <= '0;
      green_q        <= '0;
      blue_q         <= '0;
    end else begin
      state_q        <= state_d;
      seq_ready_q    <= seq_ready_d;
      burst_done_q   <= burst_done_d;
      rgf_wr_en_q    <= rgf_wr_en_d;
      rgf_addr_q     <= rgf_addr_d;
      rgf_offset_q   <= rgf_offset_d;
      rgf_wdata_q    <= rgf_wdata_d;
      pix_valid_q    <= pix_valid_d;
      pix_r_q        <= pix_r_d;
      pix_g_q        <= pix_g_d;
      pix_b_q        <= pix_b_d;
      pix_last_q     <= pix_last_d;
      burst_active_q <= burst_active_d;
      err_q          <= err_d;
      remaining_q    <= remaining_d;
      lane_q         <= lane_d;
      done_cnt_q     <= done_cnt_d;
      red_q          <= red_d;
      green_q        <= green_d;
      blue_q         <= blue_d;
    end
  end

  assign bus.sys_seq_ready  = seq_ready_q;
  assign bus.sys_burst_done = burst_done_q;
  assign bus.rgf_wr_en      = rgf_wr_en_q;
  assign bus.rgf_addr       = rgf_addr_q;
  assign bus.rgf_offset     = rgf_offset_q;
  assign bus.rgf_wdata      = rgf_wdata_q;
  assign bus.pix_valid      = pix_valid_q;
  assign bus.pix_r          = pix_r_q;
  assign bus.pix_g          = pix_g_q;
  assign bus.pix_b          = pix_b_q;
  assign bus.pix_last       = pix_last_q;
  assign bus.burst_active   = burst_active_q;
  assign bus.err_pulse      = err_q;

endmodule

`default_nettype wire
